// File: rtl/dma_ctrl.sv
// dma_ctrl: frame sequencer issuing read burst, rotate-core run and write burst per chunk
module dma_ctrl #(
  parameter int BURST_LEN = 16
) (
  input  logic        I_DCTRL_HCLK,
  input  logic        I_DCTRL_HRESET_N,
  input  logic        I_DCTRL_START,
  input  logic        I_DCTRL_ABORT,
  input  logic [31:0] I_DCTRL_SRC_BASE,
  input  logic [31:0] I_DCTRL_DST_BASE,
  input  logic [15:0] I_DCTRL_NWORDS,
  input  logic        I_DCTRL_DMA_DONE,
  input  logic        I_DCTRL_PROC_DONE,
  output logic        O_DCTRL_DMA_START,
  output logic [31:0] O_DCTRL_DMA_ADDR,
  output logic [4:0]  O_DCTRL_DMA_COUNT,
  output logic [2:0]  O_DCTRL_DMA_SIZE,
  output logic        O_DCTRL_DMA_WRITE,
  output logic        O_DCTRL_DMA_RESET,
  output logic        O_DCTRL_PROC_START,
  output logic        O_DCTRL_BUSY,
  output logic        O_DCTRL_DONE
);
  localparam logic [2:0] IDLE = 3'd0, RD_REQ = 3'd1, RD_WAIT = 3'd2, PROC = 3'd3, WR_REQ = 3'd4, WR_WAIT = 3'd5;
  localparam logic [15:0] BL = 16'(BURST_LEN);
  logic [2:0]  state;
  logic [31:0] src_base, dst_base;
  logic [15:0] remaining, offset;
  logic [4:0]  count;
  logic        proc_pend;
  assign count = (remaining > BL) ? 5'(BURST_LEN) : remaining[4:0];
  assign O_DCTRL_DMA_SIZE = 3'b010;
  always_ff @(posedge I_DCTRL_HCLK or negedge I_DCTRL_HRESET_N)
    if (!I_DCTRL_HRESET_N) begin
      state <= IDLE;
      src_base <= '0;
      dst_base <= '0;
      remaining <= '0;
      offset <= '0;
      proc_pend <= 1'b0;
      O_DCTRL_DMA_START <= 1'b0;
      O_DCTRL_DMA_ADDR <= '0;
      O_DCTRL_DMA_COUNT <= '0;
      O_DCTRL_DMA_WRITE <= 1'b0;
      O_DCTRL_DMA_RESET <= 1'b0;
      O_DCTRL_PROC_START <= 1'b0;
      O_DCTRL_BUSY <= 1'b0;
      O_DCTRL_DONE <= 1'b0;
    end else begin
      O_DCTRL_DMA_START <= 1'b0;
      O_DCTRL_DMA_RESET <= 1'b0;
      O_DCTRL_PROC_START <= 1'b0;
      O_DCTRL_DONE <= 1'b0;
      proc_pend <= 1'b0;
      if (I_DCTRL_ABORT && state != IDLE) begin
        state <= IDLE;
        O_DCTRL_DMA_RESET <= 1'b1;
        O_DCTRL_BUSY <= 1'b0;
      end else
        case (state)
          IDLE:
            if (I_DCTRL_START) begin
              if (I_DCTRL_NWORDS != '0) begin
                src_base <= I_DCTRL_SRC_BASE;
                dst_base <= I_DCTRL_DST_BASE;
                remaining <= I_DCTRL_NWORDS;
                offset <= '0;
                state <= RD_REQ;
                O_DCTRL_BUSY <= 1'b1;
              end else
                O_DCTRL_DONE <= 1'b1;
            end
          RD_REQ: begin
            O_DCTRL_DMA_START <= 1'b1;
            O_DCTRL_DMA_ADDR <= src_base + {14'd0, offset, 2'b00};
            O_DCTRL_DMA_COUNT <= count;
            O_DCTRL_DMA_WRITE <= 1'b0;
            state <= RD_WAIT;
          end
          RD_WAIT:
            if (I_DCTRL_DMA_DONE) begin
              state <= PROC;
              proc_pend <= 1'b1;
            end
          PROC: begin
            O_DCTRL_PROC_START <= proc_pend;
            if (I_DCTRL_PROC_DONE) state <= WR_REQ;
          end
          WR_REQ: begin
            O_DCTRL_DMA_START <= 1'b1;
            O_DCTRL_DMA_ADDR <= dst_base + {14'd0, offset, 2'b00};
            O_DCTRL_DMA_COUNT <= count;
            O_DCTRL_DMA_WRITE <= 1'b1;
            state <= WR_WAIT;
          end
          WR_WAIT:
            if (I_DCTRL_DMA_DONE) begin
              remaining <= remaining - 16'(count);
              offset <= offset + 16'(count);
              if (remaining == 16'(count)) begin
                state <= IDLE;
                O_DCTRL_DONE <= 1'b1;
                O_DCTRL_BUSY <= 1'b0;
              end else
                state <= RD_REQ;
            end
          default: begin
            state <= IDLE;
            O_DCTRL_BUSY <= 1'b0;
          end
        endcase
    end
endmodule

// File: doc/dma_ctrl.md
DMA_CTRL -- requirements
Module: dma_ctrl

Interface
REQ-001 The block SHALL provide parameter BURST_LEN, default 16, meaning the maximum words per DMA burst (legal range 1..16).
REQ-002 The block SHALL provide the following ports, in this order:
- I_DCTRL_HCLK  in  1  single clock; all flops rise-edge.
- I_DCTRL_HRESET_N  in  1  asynchronous active-low reset.
- I_DCTRL_START  in  1  frame start pulse.
- I_DCTRL_ABORT  in  1  synchronous abort.
- I_DCTRL_SRC_BASE  in  32  source byte address.
- I_DCTRL_DST_BASE  in  32  destination byte address.
- I_DCTRL_NWORDS  in  16  frame length in 32-bit words.
- I_DCTRL_DMA_DONE  in  1  DMA burst-complete pulse.
- I_DCTRL_PROC_DONE  in  1  rotate core finished current buffer.
- O_DCTRL_DMA_START  out  1  DMA burst launch pulse.
- O_DCTRL_DMA_ADDR  out  32  burst start byte address.
- O_DCTRL_DMA_COUNT  out  5  burst beats, 1..BURST_LEN.
- O_DCTRL_DMA_SIZE  out  3  transfer size.
- O_DCTRL_DMA_WRITE  out  1  1 = write burst, 0 = read burst.
- O_DCTRL_DMA_RESET  out  1  soft reset pulse to the DMA.
- O_DCTRL_PROC_START  out  1  rotate core start pulse.
- O_DCTRL_BUSY  out  1  frame in progress.
- O_DCTRL_DONE  out  1  frame complete pulse.

Function
REQ-003 The block SHALL implement FSM states IDLE, RD_REQ, RD_WAIT, PROC, WR_REQ, WR_WAIT; all outputs SHALL be registered.
REQ-004 In IDLE, when START=1 and NWORDS!=0, the block SHALL latch SRC_BASE, DST_BASE and NWORDS into remaining, clear offset to 0, and go to RD_REQ.
REQ-005 In IDLE, when START=1 and NWORDS==0, the block SHALL pulse DONE for exactly one cycle on the next cycle, stay in IDLE, and issue no DMA_START.
REQ-006 The block SHALL compute burst count as min(remaining, BURST_LEN), held constant from the REQ state through the end of its WAIT state.
REQ-007 In RD_REQ, the block SHALL, for one cycle:
- assert DMA_START;
- drive DMA_ADDR = src_base + offset*4, modulo 2^32;
- drive DMA_COUNT = count and DMA_WRITE = 0;
- then go to RD_WAIT.
REQ-008 In RD_WAIT, on DMA_DONE the block SHALL go to PROC and pulse PROC_START for one cycle.
REQ-009 In PROC, on PROC_DONE the block SHALL go to WR_REQ.
REQ-010 In WR_REQ, the block SHALL, for one cycle:
- assert DMA_START;
- drive DMA_ADDR = dst_base + offset*4, modulo 2^32;
- drive DMA_COUNT = count and DMA_WRITE = 1;
- then go to WR_WAIT.
REQ-011 In WR_WAIT, on DMA_DONE the block SHALL set remaining -= count and offset += count, then:
- if the new remaining is 0, go to IDLE and pulse DONE for one cycle;
- otherwise, go to RD_REQ.
REQ-012 DMA_ADDR, DMA_COUNT and DMA_WRITE SHALL hold their values outside REQ cycles.
REQ-013 DMA_SIZE SHALL be constant 3'b010 (word).
REQ-014 BUSY SHALL be 1 in every state except IDLE.
REQ-015 START while BUSY=1 SHALL be ignored.
REQ-016 DMA_DONE outside RD_WAIT and WR_WAIT, and PROC_DONE outside PROC, SHALL be ignored.
REQ-017 ABORT in any non-IDLE state SHALL, on the next cycle:
- pulse DMA_RESET for one cycle;
- go to IDLE with no DONE pulse.
ABORT SHALL take priority over a simultaneous DMA_DONE or PROC_DONE. ABORT in IDLE SHALL have no effect.
REQ-018 Latency: START sampled at edge k SHALL give DMA_START=1 in the cycle after edge k+1. DMA_DONE at edge j SHALL give PROC_START=1 after edge j+1.

Reset
REQ-019 While HRESET_N=0, the block SHALL asynchronously force:
- state = IDLE;
- all registers and all outputs = 0, except DMA_SIZE = 3'b010.
REQ-020 Reset asserted mid-frame SHALL discard the frame with no DONE and no DMA_RESET pulse.
REQ-021 After HRESET_N deasserts, the block SHALL accept START on the first rising edge.

Verification
REQ-022 The bench SHALL cover a full frame (BURST_LEN=16, NWORDS=40, SRC=0x1000, DST=0x2000):
- reads at 0x1000/16, 0x1040/16, 0x1080/8;
- each read followed by PROC_START, then a write at 0x2000/16, 0x2040/16, 0x2080/8;
- exactly one DONE pulse, after the third write DMA_DONE.
REQ-023 The bench SHALL cover NWORDS=0: START -> DONE one cycle later, BUSY stays 0, no DMA_START.
REQ-024 The bench SHALL cover abort: ABORT asserted in PROC -> DMA_RESET 1-cycle pulse, IDLE, BUSY=0, no DONE; a new START then runs normally.
REQ-025 The bench SHALL cover ignored events:
- START in RD_WAIT does not restart the frame;
- DMA_DONE in PROC causes no state change;
- PROC_DONE in RD_WAIT causes no state change.
REQ-026 The bench SHALL cover address wrap: BURST_LEN=4, SRC=0xFFFFFFF0, NWORDS=8 -> read addresses 0xFFFFFFF0, then 0x00000000.
REQ-027 The bench SHALL cover reset mid-frame: HRESET_N low during WR_WAIT -> all outputs 0 (DMA_SIZE 3'b010) immediately, no DONE.
